// File: rtl/mem_port.sv
// Memory port stage: runs one req/ack word access per controller strobe and loads instr/mdr.
// Optional bus timeout abort with sticky bus_err is enabled by defining MEM_TIMEOUT_EN.
module mem_port #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IR,
    input  logic              MDR,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] mdr,
    output logic              stall,
    output logic              bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t            state;
    logic              ld_ir;
    logic              ld_mdr;
    logic              start_c;
    logic              expire_c;
    logic [ADDR_W-1:0] addr_sel_c;

    assign start_c    = MemRead | MemWrite;
    assign addr_sel_c = IorD ? alu_out : pc;
    assign stall      = ((state == S_IDLE) && start_c) || (state == S_REQ);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             bus_err_q;

    // Counter holds the number of REQ cycles already spent without ack.
    assign expire_c = (cnt == CNT_W'(TIMEOUT - 1));
    assign bus_err  = bus_err_q;
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT != 0);
    assign expire_c       = 1'b0;
    assign bus_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            instr     <= '0;
            mdr       <= '0;
            ld_ir     <= 1'b0;
            ld_mdr    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt       <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_c) begin
                        mem_addr  <= addr_sel_c & ~ADDR_W'(3);
                        mem_we    <= MemWrite;
                        mem_wdata <= wdata;
                        ld_ir     <= IR & ~MemWrite;
                        ld_mdr    <= MDR & ~MemWrite;
                        mem_req   <= 1'b1;
                        state     <= S_REQ;
`ifdef MEM_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end
                end
                S_REQ: begin
                    // Ack wins over an expiring timeout in the same cycle.
                    if (mem_ack) begin
                        if (ld_ir)  instr <= mem_rdata;
                        if (ld_mdr) mdr   <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_DONE;
                    end else if (expire_c) begin
                        mem_req <= 1'b0;
                        state   <= S_DONE;
`ifdef MEM_TIMEOUT_EN
                        bus_err_q <= 1'b1;
`endif
                    end else begin
`ifdef MEM_TIMEOUT_EN
                        cnt <= cnt + CNT_W'(1);
`endif
                    end
                end
                S_DONE: begin
                    mem_we <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: expected instr/mdr pushed to a scoreboard at strobe time, popped in DONE.
module tb_mem_port;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          nrst;
    logic          MemRead, MemWrite, IorD, IR, MDR;
    logic [AW-1:0] pc, alu_out;
    logic [DW-1:0] wdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, instr, mdr;
    logic          stall, bus_err;

    always #5 clk = ~clk;

    mem_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
        .clk(clk), .nrst(nrst),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IR(IR), .MDR(MDR),
        .pc(pc), .alu_out(alu_out), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .mdr(mdr), .stall(stall), .bus_err(bus_err)
    );

    typedef struct {
        logic [DW-1:0] instr;
        logic [DW-1:0] mdr;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] m_instr, m_mdr;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_strobes(input logic rd, input logic wr, input logic iord,
                               input logic ir, input logic md);
        MemRead = rd; MemWrite = wr; IorD = iord; IR = ir; MDR = md;
    endtask

    // One access: strobe in IDLE, (waits+1) REQ cycles with ack on the last, then DONE.
    task automatic do_access(input logic rd, input logic wr, input logic iord, input logic ir,
                             input logic md, input int waits, input logic [DW-1:0] rdata,
                             input bit hold);
        logic [AW-1:0] ea;
        exp_t          e;
        ea = (iord ? alu_out : pc) & ~AW'(3);
        @(posedge clk); #1;
        set_strobes(rd, wr, iord, ir, md);
        if (!wr) begin
            if (ir) m_instr = rdata;
            if (md) m_mdr   = rdata;
        end
        sb.push_back('{m_instr, m_mdr});
        @(negedge clk);
        check("idle_stall", stall, 1'b1);
        check("idle_req", mem_req, 1'b0);
        check("idle_we", mem_we, 1'b0);
        for (int c = 0; c <= waits; c++) begin
            @(posedge clk); #1;
            mem_ack   = (c == waits);
            mem_rdata = rdata;
            @(negedge clk);
            check("req_req", mem_req, 1'b1);
            check("req_stall", stall, 1'b1);
            check("req_addr", mem_addr, ea);
            check("req_we", mem_we, wr);
            check("req_wdata", mem_wdata, wdata);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (!hold) set_strobes(0, 0, 0, 0, 0);
        @(negedge clk);
        check("done_req", mem_req, 1'b0);
        check("done_stall", stall, 1'b0);
        check("sb_nonempty", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("done_instr", instr, e.instr);
            check("done_mdr", mdr, e.mdr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; set_strobes(0, 0, 0, 0, 0);
        pc = '0; alu_out = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        m_instr = '0; m_mdr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, '0);
        check("rst_wdata", mem_wdata, '0);
        check("rst_instr", instr, '0);
        check("rst_mdr", mdr, '0);
        check("rst_stall", stall, 1'b0);
        check("rst_err", bus_err, 1'b0);
        #1 nrst = 1'b1;

        // Fetch, zero wait
        pc = 32'h0000_0040;
        do_access(1, 0, 0, 1, 0, 0, 32'h2010_0005, 0);
        // Load with 3 wait states, unaligned address
        alu_out = 32'h0000_0103;
        do_access(1, 0, 1, 0, 1, 3, 32'hDEAD_BEEF, 0);
        // Store with MemRead also high and load intents set: no register update
        alu_out = 32'h0000_0080; wdata = 32'h1234_5678;
        do_access(1, 1, 1, 1, 1, 0, 32'hCAFE_F00D, 0);
        // Read loading both registers
        pc = 32'h0000_0044; wdata = 32'h0;
        do_access(1, 0, 0, 1, 1, 1, 32'h0BAD_F00D, 0);

        // Strobes held through DONE: second access only via the following IDLE cycle
        pc = 32'h0000_0048;
        do_access(1, 0, 0, 1, 0, 0, 32'h1111_2222, 1);
        do_access(1, 0, 0, 1, 0, 2, 32'h3333_4444, 1);
        @(posedge clk); #1;
        set_strobes(0, 0, 0, 0, 0);
        @(negedge clk);
        check("hold_idle_req", mem_req, 1'b0);
        check("hold_idle_stall", stall, 1'b0);
        @(posedge clk); @(negedge clk);
        check("hold_idle_req2", mem_req, 1'b0);

        // Reset during the second wait cycle of a read
        pc = 32'h0000_0060;
        @(posedge clk); #1;
        set_strobes(1, 0, 0, 1, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        nrst = 1'b0;
        @(negedge clk);
        check("mid_req_before", mem_req, 1'b1);
        @(posedge clk); #1;
        m_instr = '0; m_mdr = '0;
        @(negedge clk);
        check("mid_rst_req", mem_req, 1'b0);
        check("mid_rst_instr", instr, '0);
        check("mid_rst_mdr", mdr, '0);
        check("mid_rst_stall", stall, 1'b1);
        @(posedge clk); #1;
        nrst = 1'b1; set_strobes(0, 0, 0, 0, 0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("late_ack_stall", stall, 1'b0);
        check("late_ack_req", mem_req, 1'b0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_instr", instr, '0);
        check("late_ack_mdr", mdr, '0);
        check("late_ack_req2", mem_req, 1'b0);

        // Recovery after reset
        pc = 32'h0000_0070;
        do_access(1, 0, 0, 1, 0, 0, 32'h5555_AAAA, 0);

`ifdef MEM_TIMEOUT_EN
        // Ack on the 15th REQ cycle completes normally
        alu_out = 32'h0000_0200;
        do_access(1, 0, 1, 0, 1, 14, 32'h7777_8888, 0);
        check("to_ack_err", bus_err, 1'b0);
        // No ack: abort after 15 REQ cycles
        @(posedge clk); #1;
        set_strobes(1, 0, 1, 0, 1);
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("to_req_high", mem_req, 1'b1);
        end
        @(posedge clk); #1;
        set_strobes(0, 0, 0, 0, 0);
        @(negedge clk);
        check("to_req_drop", mem_req, 1'b0);
        check("to_err_set", bus_err, 1'b1);
        check("to_stall", stall, 1'b0);
        check("to_mdr", mdr, m_mdr);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("to_err_sticky", bus_err, 1'b1);
`else
        // Without the timeout a long wait simply completes
        alu_out = 32'h0000_0204;
        do_access(1, 0, 1, 0, 1, 20, 32'h9999_0000, 0);
        check("no_to_err", bus_err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
